pe_network_interface: RTL and testbench
=======================================

// Module: pe_network_interface
// PURPOSE
//   Network interface between a processing element (PE) and the pe port of one mesh router.
//   TX: accepts {dest, 32-bit payload} from the PE and builds the 64-bit flit header
//   (VC, direction, hop counts, source). It then queues the flit and injects it on pesi/pedi.
//   RX: consumes flits from peso/pedo, strips the header and presents payload + source to the PE.
//   Self-addressed packets never enter the router; they loop back internally.
// PARAMETERS
//   TX_DEPTH  4  TX FIFO entries, power of 2, >=2
//   RX_DEPTH  2  RX FIFO entries, power of 2, >=2
// PORTS
//   clk              in   1   clock
//   reset            in   1   synchronous, active-high
//   router_position  in   4   [3:2]=Y, [1:0]=X of the attached router
//   polarity         in   1   router polarity_out; toggles every cycle
//   tx_valid         in   1   PE send request
//   tx_ready         out  1   TX FIFO not full
//   tx_dest          in   4   [3:2]=dest Y, [1:0]=dest X
//   tx_data          in   32  payload
//   pesi             out  1   flit valid to router pe input channel
//   pedi             out  64  flit to router
//   peri             in   1   router pe input channel ready
//   peso             in   1   flit valid from router pe output channel
//   pedo             in   64  flit from router
//   pero             out  1   NIC can accept a flit (RX FIFO not full)
//   rx_valid         out  1   payload available to PE
//   rx_ready         in   1   PE accepts payload
//   rx_data          out  32  received payload
//   rx_src           out  4   {src Y[1:0], src X[1:0]} from header bits [41:40],[33:32]
// BEHAVIOUR
//   Flit format:
//     [63] VC | [62] NS (0=N->S, Y increasing; 1=S->N) | [61] EW (0=E->W, X decreasing; 1=W->E)
//     [60:56] 0 | [55:52] Y hops | [51:48] X hops | [47:40] src Y (zero-extended)
//     [39:32] src X (zero-extended) | [31:0] payload
//   Header build at TX accept:
//     hops = |dest - pos| per axis; NS = (destY < posY); EW = (destX > posX).
//     Direction bit = 0 on an axis with zero hops.
//   Self-address (dest == router_position):
//     - Not written to the TX FIFO; pushed straight into the RX FIFO.
//     - tx_ready for such a request = RX FIFO not full this cycle.
//     - Loopback wins over a simultaneous peso capture. pero is deasserted in any cycle a
//       loopback push could occur, i.e. tx_valid && self-address.
//   TX accept: tx_valid && tx_ready on a rising clk edge. FIFO push; header fields latched.
//   Injection FSM states:
//     IDLE: enter SEND when FIFO is non-empty.
//     SEND: pesi=1 and pedi=head flit with [63]=polarity of that cycle, only while peri=1.
//           Pop on the edge; 1 flit/cycle max.
//           Go to IDLE if the FIFO is then empty, else stay in SEND.
//     Stall: peri=0 in SEND gives pesi=0 and pedi=0; the head is held.
//   pedi is 64'b0 whenever pesi=0. A routed flit always has nonzero hops, so it is never all-zero.
//   TX latency: accept at edge N gives pesi at cycle N+1 at earliest (peri=1, FIFO empty).
//   RX:
//     - pero = !rx_full. peso && pero captures pedo at the edge.
//     - peso while pero=0 is a protocol violation; the flit is dropped (see NIC_STATS_EN).
//     - rx_valid is high while the RX FIFO is non-empty; rx_data/rx_src come from the head.
//     - Pop on rx_valid && rx_ready. Push and pop in the same cycle are allowed when full.
//     - RX latency: peso at edge N gives rx_valid in cycle N+1.
//   Full/empty boundaries:
//     - TX full: tx_ready=0, except self-address requests, which use RX-full instead.
//     - TX simultaneous push+pop while full: the pop happens, and the push is refused because
//       tx_ready was 0 that cycle.
//     - Pointers are log2(DEPTH)+1 bits wide with a wrap bit.
//   Reset (any cycle, mid-packet included):
//     - FIFOs are emptied and the FSM goes to IDLE.
//     - Outputs: pesi=0, pedi=0, pero=0 during reset, then 1 from the first cycle after.
//     - Outputs: tx_ready=0 during reset, rx_valid=0, rx_data=0, rx_src=0.
//     - A flit in flight is lost.
// CONFIGURATION
//   NIC_STATS_EN defined:
//     - Adds tx_count[15:0], rx_count[15:0] and drop_count[7:0] as output ports.
//     - tx_count: +1 per pesi&&peri. rx_count: +1 per RX push, loopback included.
//     - drop_count: +1 per peso&&!pero, saturating.
//     - All three wrap/saturate as stated, clear on reset and are registered outputs.
//   NIC_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//   Shared package noc_pkg:
//     - Flit bit positions: VC=63, NS=62, EW=61, YHOP 55:52, XHOP 51:48, SRCY 47:40,
//       SRCX 39:32, DATA 31:0.
//     - Direction encodings.
//     - Function build_header(pos, dest).
//   Sub-module nic_fifo #(WIDTH, DEPTH): sync FIFO with full/empty. Instantiated for TX (64b)
//   and RX (36b).
// TESTING
//   1. pos=4'b0101, tx dest=4'b1100, data=32'hDEAD_BEEF, peri=1.
//      Expect pesi one cycle later with pedi[62:0]=63'h0021_0101_DEAD_BEEF and [63]=polarity.
//   2. Hold peri=0, push 4 flits.
//      Expect tx_ready=0 after the 4th and no pesi. Release peri: expect 4 back-to-back pesi in
//      order, then IDLE.
//   3. pos=4'b0110, tx dest=4'b0110, data=32'h1234.
//      Expect no pesi; rx_valid next cycle with rx_data=32'h1234, rx_src=4'b0110.
//   4. rx_ready=0, drive 2 peso flits.
//      Expect pero=0 after the 2nd. Assert rx_ready: expect in-order pops with rx_src decoded
//      from [41:40],[33:32].
//   5. Reset asserted with 3 flits queued and rx_valid=1.
//      Next cycle expect pesi=0, rx_valid=0, pero=0. After release pero=1 and no stale flits.
//   6. NIC_STATS_EN: send 3 flits, receive 2 plus 1 loopback, 1 peso while full.
//      Expect tx_count=3, rx_count=3, drop_count=1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions, direction encodings and the
// header builder used by the PE network interface.
package noc_pkg;

   localparam int FLIT_W  = 64;
   localparam int DATA_W  = 32;
   localparam int RX_W    = 36;   // {src Y, src X, payload}

   localparam int VC_BIT  = 63;
   localparam int NS_BIT  = 62;
   localparam int EW_BIT  = 61;
   localparam int YHOP_HI = 55;
   localparam int YHOP_LO = 52;
   localparam int XHOP_HI = 51;
   localparam int XHOP_LO = 48;
   localparam int SRCY_HI = 47;
   localparam int SRCY_LO = 40;
   localparam int SRCX_HI = 39;
   localparam int SRCX_LO = 32;
   localparam int DATA_HI = 31;
   localparam int DATA_LO = 0;

   typedef enum logic {NS_N2S = 1'b0, NS_S2N = 1'b1} ns_dir_e;
   typedef enum logic {EW_E2W = 1'b0, EW_W2E = 1'b1} ew_dir_e;
   typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} inj_state_e;

   // Header word with VC=0 and payload=0. A zero-hop axis never satisfies the
   // strict compare, so its direction bit naturally stays 0.
   function automatic logic [FLIT_W-1:0] build_header(input logic [3:0] pos,
                                                      input logic [3:0] dest);
      logic [FLIT_W-1:0] f;
      logic [1:0]        py, px, dy, dx;
      ns_dir_e           ns;
      ew_dir_e           ew;
      py = pos[3:2];
      px = pos[1:0];
      dy = dest[3:2];
      dx = dest[1:0];
      ns = (dy < py) ? NS_S2N : NS_N2S;
      ew = (dx > px) ? EW_W2E : EW_E2W;
      f  = '0;
      f[NS_BIT]            = ns;
      f[EW_BIT]            = ew;
      f[YHOP_HI:YHOP_LO]   = {2'b00, (dy > py) ? (dy - py) : (py - dy)};
      f[XHOP_HI:XHOP_LO]   = {2'b00, (dx > px) ? (dx - px) : (px - dx)};
      f[SRCY_HI:SRCY_LO]   = {6'b0, py};
      f[SRCX_HI:SRCX_LO]   = {6'b0, px};
      return f;
   endfunction

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is taken only if a
// pop happens in the same cycle. empty_next is the emptiness after this edge.
module nic_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             empty_next
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_en, pop_en;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign dout    = mem_q[rptr_q[AW-1:0]];

   // Next pointers and storage write.
   always_comb begin
      wptr_d = push_en ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop_en  ? rptr_q + 1'b1 : rptr_q;
      mem_d  = mem_q;
      if (push_en) mem_d[wptr_q[AW-1:0]] = din;
   end

   assign empty_next = (wptr_d == rptr_d);

   // Pointers clear on reset; stored data is left as-is.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pe_network_interface.sv
// PE <-> router network interface. TX builds flit headers, queues and injects;
// RX strips headers and queues payloads; self-addressed sends loop back.
// Optional statistics counters are enabled with the NIC_STATS_EN macro.
module pe_network_interface #(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  router_position,
   input  logic        polarity,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [3:0]  tx_dest,
   input  logic [31:0] tx_data,
   output logic        pesi,
   output logic [63:0] pedi,
   input  logic        peri,
   input  logic        peso,
   input  logic [63:0] pedo,
   output logic        pero,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [31:0] rx_data,
   output logic [3:0]  rx_src
`ifdef NIC_STATS_EN
   ,
   output logic [15:0] tx_count,
   output logic [15:0] rx_count,
   output logic [7:0]  drop_count
`endif
);

   import noc_pkg::*;

   logic              self_addr, tx_acc, tx_push, tx_pop, loop_push;
   logic              rx_cap, rx_push, rx_pop;
   logic              tx_full, tx_empty, tx_empty_next;
   logic              rx_full, rx_empty, rx_empty_next;
   logic [FLIT_W-1:0] tx_din, tx_head;
   logic [RX_W-1:0]   rx_din, rx_head;
   inj_state_e        state_q, state_d;
   logic              rx_valid_q, rx_valid_d;
   logic              unused_bits;

   // Self-addressed requests are gated by RX space, everything else by TX space.
   assign self_addr = (tx_dest == router_position);
   assign tx_ready  = !reset && (self_addr ? !rx_full : !tx_full);
   assign tx_acc    = tx_valid && tx_ready;
   assign tx_push   = tx_acc && !self_addr;
   assign loop_push = tx_acc && self_addr;
   assign tx_din    = build_header(router_position, tx_dest) | {32'b0, tx_data};

   // Router injection; VC is stamped with the live polarity, not the queued bit.
   assign pesi   = !reset && (state_q == ST_SEND) && peri && !tx_empty;
   assign tx_pop = pesi;
   assign pedi   = pesi ? {polarity, tx_head[VC_BIT-1:0]} : '0;

   // pero drops whenever a loopback could claim the RX write port.
   assign pero    = !reset && !rx_full && !(tx_valid && self_addr);
   assign rx_cap  = peso && pero;
   assign rx_push = loop_push || rx_cap;
   assign rx_din  = loop_push ? {router_position, tx_data}
                              : {pedo[SRCY_LO+1:SRCY_LO], pedo[SRCX_LO+1:SRCX_LO],
                                 pedo[DATA_HI:DATA_LO]};

   assign rx_valid = rx_valid_q && !reset;
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_data  = (rx_valid && !rx_empty) ? rx_head[DATA_W-1:0] : '0;
   assign rx_src   = (rx_valid && !rx_empty) ? rx_head[RX_W-1:DATA_W] : '0;

   // Header bits that the RX side and injection path intentionally ignore.
   assign unused_bits = ^{pedo[63:42], pedo[39:34], tx_head[VC_BIT]};

   nic_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (tx_push),
      .din        (tx_din),
      .pop        (tx_pop),
      .dout       (tx_head),
      .full       (tx_full),
      .empty      (tx_empty),
      .empty_next (tx_empty_next)
   );

   nic_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (rx_push),
      .din        (rx_din),
      .pop        (rx_pop),
      .dout       (rx_head),
      .full       (rx_full),
      .empty      (rx_empty),
      .empty_next (rx_empty_next)
   );

   // Injection FSM next state: SEND exactly while the TX queue holds a flit.
   always_comb begin
      state_d    = state_q;
      rx_valid_d = !rx_empty_next;
      case (state_q)
         ST_IDLE: if (!tx_empty_next) state_d = ST_SEND;
         ST_SEND: if (tx_empty_next)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and registered RX valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_valid_q <= rx_valid_d;
      end
   end

`ifdef NIC_STATS_EN
   logic [15:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic [7:0]  drop_count_q, drop_count_d;

   // Traffic counters: wrapping TX/RX, saturating drop.
   always_comb begin
      tx_count_d   = tx_count_q;
      rx_count_d   = rx_count_q;
      drop_count_d = drop_count_q;
      if (pesi) tx_count_d = tx_count_q + 16'd1;
      if (rx_push) rx_count_d = rx_count_q + 16'd1;
      if (peso && !pero && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_count_q   <= '0;
         rx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         tx_count_q   <= tx_count_d;
         rx_count_q   <= rx_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx_count   = tx_count_q;
   assign rx_count   = rx_count_q;
   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_pe_network_interface.sv
// Directed bench for pe_network_interface: header build, back-pressure,
// loopback, RX queueing, mid-traffic reset and (with NIC_STATS_EN) counters.
module tb_pe_network_interface;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  router_position = '0;
   logic        polarity = 1'b0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [3:0]  tx_dest = '0;
   logic [31:0] tx_data = '0;
   logic        pesi;
   logic [63:0] pedi;
   logic        peri = 1'b0;
   logic        peso = 1'b0;
   logic [63:0] pedo = '0;
   logic        pero;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic [31:0] rx_data;
   logic [3:0]  rx_src;
`ifdef NIC_STATS_EN
   logic [15:0] tx_count, rx_count;
   logic [7:0]  drop_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   pe_network_interface #(.TX_DEPTH(4), .RX_DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .router_position (router_position),
      .polarity        (polarity),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .tx_dest         (tx_dest),
      .tx_data         (tx_data),
      .pesi            (pesi),
      .pedi            (pedi),
      .peri            (peri),
      .peso            (peso),
      .pedo            (pedo),
      .pero            (pero),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .rx_src          (rx_src)
`ifdef NIC_STATS_EN
      ,
      .tx_count        (tx_count),
      .rx_count        (rx_count),
      .drop_count      (drop_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; the router's polarity toggles every cycle.
   task automatic tick;
      @(posedge clk);
      #1;
      polarity = ~polarity;
   endtask

   initial begin
      // Reset state
      tick; tick;
      #1;
      chk("rst_pesi", pesi, 0);
      chk("rst_pero", pero, 0);
      chk("rst_txrdy", tx_ready, 0);
      chk("rst_rxv", rx_valid, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_pero", pero, 1);

      // 1: single routed flit, header build
      router_position = 4'b0101;
      tx_dest = 4'b1100; tx_data = 32'hDEAD_BEEF; tx_valid = 1'b1; peri = 1'b1;
      #1 chk("t1_txrdy", tx_ready, 1);
      tick;
      tx_valid = 1'b0;
      #1;
      chk("t1_pesi", pesi, 1);
      chk("t1_pedi", pedi, {polarity, 63'h0021_0101_DEAD_BEEF});
      tick;
      #1;
      chk("t1_idle_pesi", pesi, 0);
      chk("t1_idle_pedi", pedi, 0);

      // 2: fill TX with router stalled, then drain; push while full+pop refused
      peri = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tx_valid = 1'b1; tx_data = 32'h100 + i;
         #1 chk("t2_txrdy", tx_ready, 1);
         tick;
         #1 chk("t2_stall_pesi", pesi, 0);
      end
      tx_data = 32'h999;
      #1 chk("t2_full", tx_ready, 0);
      peri = 1'b1;
      #1;
      chk("t2_full_pop_rdy", tx_ready, 0);
      chk("t2_pesi0", pesi, 1);
      chk("t2_data0", pedi[31:0], 32'h100);
      tick;
      tx_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         #1;
         chk("t2_pesi", pesi, 1);
         chk("t2_data", pedi[31:0], 32'h100 + i);
         chk("t2_vc", pedi[63], polarity);
         tick;
      end
      #1 chk("t2_idle", pesi, 0);
      tick;
      #1 chk("t2_no_999", pesi, 0);

      // 3: self-addressed loopback
      router_position = 4'b0110;
      tx_dest = 4'b0110; tx_data = 32'h1234; tx_valid = 1'b1; rx_ready = 1'b0;
      #1;
      chk("t3_txrdy", tx_ready, 1);
      chk("t3_pero_blk", pero, 0);
      tick;
      tx_valid = 1'b0;
      #1;
      chk("t3_pesi", pesi, 0);
      chk("t3_rxv", rx_valid, 1);
      chk("t3_rxdata", rx_data, 32'h1234);
      chk("t3_rxsrc", rx_src, 4'b0110);
      rx_ready = 1'b1;
      tick;
      rx_ready = 1'b0;
      #1 chk("t3_rxv_clr", rx_valid, 0);

      // 4: RX fill, drop when full, in-order drain with src decode
      peso = 1'b1;
      pedo = {16'h8013, 8'hFE, 8'h01, 32'hAAAA_0001};
      #1 chk("t4_pero_a", pero, 1);
      tick;
      pedo = {16'hC012, 8'h03, 8'hFC, 32'hBBBB_0002};
      #1 chk("t4_pero_b", pero, 1);
      tick;
      pedo = {16'h0011, 8'h01, 8'h01, 32'hCCCC_0003};
      #1 chk("t4_full", pero, 0);
      tick;
      peso = 1'b0;
      #1;
      chk("t4_rxv", rx_valid, 1);
      chk("t4_data_a", rx_data, 32'hAAAA_0001);
      chk("t4_src_a", rx_src, 4'b1001);
      rx_ready = 1'b1;
      tick;
      #1;
      chk("t4_data_b", rx_data, 32'hBBBB_0002);
      chk("t4_src_b", rx_src, 4'b1100);
      tick;
      #1 chk("t4_empty", rx_valid, 0);
      rx_ready = 1'b0;

      // 5: reset with traffic queued on both sides
      router_position = 4'b0101;
      peri = 1'b0; tx_dest = 4'b1100; tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_data = 32'h500 + i;
         tick;
      end
      tx_dest = 4'b0101; tx_data = 32'h55;
      tick;
      tx_valid = 1'b0;
      #1 chk("t5_pre_rxv", rx_valid, 1);
      peri = 1'b1; reset = 1'b1;
      #1;
      chk("t5_in_rst_pesi", pesi, 0);
      chk("t5_in_rst_pero", pero, 0);
      chk("t5_in_rst_txrdy", tx_ready, 0);
      tick;
      #1;
      chk("t5_rst_pesi", pesi, 0);
      chk("t5_rst_rxv", rx_valid, 0);
      chk("t5_rst_pero", pero, 0);
      chk("t5_rst_rxdata", rx_data, 0);
      reset = 1'b0;
      #1;
      chk("t5_pero", pero, 1);
      chk("t5_pesi", pesi, 0);
      tick;
      #1;
      chk("t5_stale_pesi", pesi, 0);
      chk("t5_stale_rxv", rx_valid, 0);

`ifdef NIC_STATS_EN
      // 6: statistics
      reset = 1'b1;
      tick;
      reset = 1'b0;
      router_position = 4'b0101; peri = 1'b1; tx_dest = 4'b1100; tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_data = 32'h600 + i;
         tick;
      end
      tx_valid = 1'b0;
      tick; tick;
      rx_ready = 1'b0; peso = 1'b1;
      pedo = {16'h0011, 8'h02, 8'h01, 32'h7000_0001};
      tick; tick;
      tick;
      peso = 1'b0;
      rx_ready = 1'b1;
      tick;
      rx_ready = 1'b0;
      tx_dest = 4'b0101; tx_data = 32'h77; tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      #1;
      chk("t6_tx_count", tx_count, 3);
      chk("t6_rx_count", rx_count, 3);
      chk("t6_drop_count", drop_count, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
